// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: the requester drives start and operands,
// the divider returns status and registered results.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_CHECK_EN: short-circuits a zero divisor and raises div_by_zero.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [WIDTH:0]        p_reg;
  logic [WIDTH-1:0]      q_reg;
  logic [WIDTH-1:0]      d_reg;
  logic [WIDTH-1:0]      quo_reg;
  logic [WIDTH-1:0]      rem_reg;
  logic [CNT_W-1:0]      cnt;
  logic                  last_step;
  logic                  zero_div;
  logic                  busy_c;
  logic                  done_c;
  logic [WIDTH:0]        p_shift;
  logic [WIDTH:0]        p_step;
  logic [WIDTH-1:0]      q_step;
  logic signed [WIDTH:0] trial;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_reg;
  assign zero_div        = (bus.divisor == '0);
  assign bus.div_by_zero = dbz_reg;
`else
  assign zero_div        = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  // One restoring step: shift {P,Q}, trial-subtract D, keep result if non-negative
  always_comb begin
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    trial   = $signed(p_shift) - $signed({1'b0, d_reg});
    if (!trial[WIDTH]) begin
      p_step = $unsigned(trial);
      q_step = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      p_step = p_shift;
      q_step = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = zero_div ? DONE : RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      q_reg   <= '0;
      d_reg   <= '0;
      cnt     <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          p_reg <= '0;
          q_reg <= bus.dividend;
          d_reg <= bus.divisor;
          cnt   <= '0;
`ifdef DIV_ZERO_CHECK_EN
          if (zero_div) begin
            quo_reg <= '1;
            rem_reg <= bus.dividend;
            dbz_reg <= 1'b1;
          end
`endif
        end
        RUN: begin
          p_reg <= p_step;
          q_reg <= q_step;
          cnt   <= cnt + CNT_W'(1);
          // Results come straight from the final step so they never expose partial values
          if (last_step) begin
            quo_reg <= q_step;
            rem_reg <= p_step[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
            dbz_reg <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.quotient  = quo_reg;
  assign bus.remainder = rem_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed scenarios plus a shuffled
// sweep of all operand pairs against a plain-arithmetic reference.
module tb_seq_divider;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one cycle; returns just after the accepting edge.
  task automatic launch(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic finish_op(input int a, input int b);
    int cyc;
    int eq;
    int er;
    bit zmode;
    cyc   = 0;
    zmode = (b == 0) && DZ_EN;
    while (!bus.done && cyc < 20) begin
      chk("busy_run", int'(bus.busy), 1);
      tick();
      cyc++;
    end
    chk("latency", cyc, zmode ? 0 : W);
    if (b == 0) begin
      eq = MAXV;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    chk("quotient", int'(bus.quotient), eq);
    chk("remainder", int'(bus.remainder), er);
    chk("div_by_zero", int'(bus.div_by_zero), int'(zmode));
    chk("busy_at_done", int'(bus.busy), 0);
    if (b != 0) begin
      chk("invariant", int'(bus.quotient) * b + int'(bus.remainder), a);
      chk("rem_lt_div", int'(int'(bus.remainder) < b), 1);
    end
    tick();
    chk("done_single", int'(bus.done), 0);
    chk("quot_hold", int'(bus.quotient), eq);
    chk("rem_hold", int'(bus.remainder), er);
  endtask

  task automatic run_op(input int a, input int b);
    launch(a, b);
    finish_op(a, b);
  endtask

  initial begin
    int npulse;
    int order[256];
    int j;
    int t;
    clk          = 1'b0;
    rst          = 1'b1;
    n_tests      = 0;
    n_fail       = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    tick();
    tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_rem", int'(bus.remainder), 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);
    rst = 1'b0;
    tick();

    // Basic operation and operand corners
    run_op(13, 3);
    run_op(15, 1);
    run_op(2, 7);
    run_op(0, 5);
    run_op(15, 15);
    run_op(9, 0);
    run_op(8, 2);

    // start while RUN and while DONE must be ignored
    launch(13, 3);
    npulse = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin
        bus.start    = 1'b1;
        bus.dividend = W'(6);
        bus.divisor  = W'(2);
      end
      if (k == 3) bus.start = 1'b0;
      if (k == 5) bus.start = 1'b1;
      tick();
      if (bus.done) npulse++;
      if (k <= 3) chk("ign_busy", int'(bus.busy), 1);
      if (k == 4) begin
        chk("ign_done", int'(bus.done), 1);
        chk("ign_quot", int'(bus.quotient), 4);
        chk("ign_rem", int'(bus.remainder), 1);
      end
    end
    chk("ign_pulses", npulse, 1);
    chk("ign_quot_hold", int'(bus.quotient), 4);
    tick();
    bus.start = 1'b0;
    finish_op(6, 2);

    // Reset in the third RUN cycle aborts without a done pulse
    launch(14, 4);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_quot", int'(bus.quotient), 0);
    chk("abort_rem", int'(bus.remainder), 0);
    chk("abort_dbz", int'(bus.div_by_zero), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("abort_no_done", int'(bus.done), 0);
    end
    rst = 1'b0;
    tick();
    chk("post_abort_done", int'(bus.done), 0);
    run_op(7, 2);

    // Every operand pair in shuffled order with random idle gaps
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i));
      t        = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2)) tick();
      run_op(order[i] >> W, order[i] & MAXV);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
